// File: rtl/scorer_pkg.sv
// Shared constants, FSM state type and target-table helper for truth_table_scorer.
// Sized for the default 4-input / 4-output candidate.
package scorer_pkg;

    localparam int DEF_N_IN  = 4;
    localparam int DEF_N_OUT = 4;
    localparam int N_VEC     = 2 ** DEF_N_IN;
    localparam int SCORE_W   = $clog2(DEF_N_OUT * N_VEC + 1);
    localparam int TGT_W     = DEF_N_OUT * N_VEC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Expected outputs for input vector v: bits v*N_OUT .. v*N_OUT+N_OUT-1.
    function automatic logic [DEF_N_OUT-1:0] target_slice(input logic [TGT_W-1:0]    tgt,
                                                          input logic [DEF_N_IN-1:0] v);
        return tgt[int'(v) * DEF_N_OUT +: DEF_N_OUT];
    endfunction

endpackage

// File: rtl/truth_table_scorer_match_popcount.sv
// Counts how many candidate output bits agree with the expected outputs.
// Purely combinational.
module match_popcount #(
    parameter int N_OUT = 4
) (
    input  logic [N_OUT-1:0]             actual,
    input  logic [N_OUT-1:0]             expected,
    output logic [$clog2(N_OUT+1)-1:0]   pop
);
    localparam int PW = $clog2(N_OUT + 1);

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_OUT; i++) begin
            pop = pop + PW'(~(actual[i] ^ expected[i]));
        end
    end

endmodule

// File: rtl/truth_table_scorer.sv
// Walks every input vector into an evolved candidate, waits a settle time, and
// scores the candidate's responses against a captured target truth table.
module truth_table_scorer
    import scorer_pkg::*;
#(
    // N_IN / N_OUT must match the package defaults that size target_slice.
    parameter int N_IN          = DEF_N_IN,
    parameter int N_OUT         = DEF_N_OUT,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [N_OUT*(2**N_IN)-1:0] target,
    output logic [N_IN-1:0]            dut_in,
    input  logic [N_OUT-1:0]           dut_out,
    output logic                       busy,
    output logic                       done,
    output logic [SCORE_W-1:0]         score,
    output logic [(2**N_IN)-1:0]       mismatch_mask
);
    localparam int                PW       = $clog2(N_OUT + 1);
    localparam int                CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]   LAST_VEC = {N_IN{1'b1}};

    state_t                     state_q, state_d;
    logic [N_OUT*(2**N_IN)-1:0] target_q, target_d;
    logic [N_IN-1:0]            vec_q, vec_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [SCORE_W-1:0]         acc_q, acc_d;
    logic [(2**N_IN)-1:0]       wmask_q, wmask_d;
    logic [N_IN-1:0]            dut_in_q, dut_in_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [SCORE_W-1:0]         score_q, score_d;
    logic [(2**N_IN)-1:0]       mmask_q, mmask_d;

    logic [N_OUT-1:0]           exp_slice;
    logic [PW-1:0]              pop;
    logic [SCORE_W-1:0]         acc_sum;
    logic [(2**N_IN)-1:0]       mask_upd;

    assign exp_slice = target_slice(target_q, vec_q);

    match_popcount #(.N_OUT(N_OUT)) u_match_popcount (
        .actual   (dut_out),
        .expected (exp_slice),
        .pop      (pop)
    );

    // Running totals including the vector currently being sampled.
    always_comb begin
        acc_sum  = acc_q + SCORE_W'(pop);
        mask_upd = wmask_q;
        if (pop != PW'(N_OUT)) begin
            mask_upd[vec_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        wmask_d  = wmask_q;
        dut_in_d = dut_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        score_d  = score_q;
        mmask_d  = mmask_q;
        case (state_q)
            ST_IDLE: begin
                busy_d   = 1'b0;
                dut_in_d = '0;
                if (start) begin
                    target_d = target;
                    acc_d    = '0;
                    wmask_d  = '0;
                    vec_d    = '0;
                    cnt_d    = CNT_LOAD;
                    busy_d   = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                acc_d   = acc_sum;
                wmask_d = mask_upd;
                if (vec_q == LAST_VEC) begin
                    score_d = acc_sum;
                    mmask_d = mask_upd;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    vec_d    = vec_q + N_IN'(1);
                    dut_in_d = vec_q + N_IN'(1);
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_WAIT;
                end
            end
            ST_DONE: begin
                busy_d   = 1'b0;
                dut_in_d = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            vec_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            wmask_q  <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            score_q  <= '0;
            mmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            wmask_q  <= wmask_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            score_q  <= score_d;
            mmask_q  <= mmask_d;
        end
    end

    assign dut_in        = dut_in_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign score         = score_q;
    assign mismatch_mask = mmask_q;

endmodule

// File: tb/tb_truth_table_scorer.sv
// Bench for truth_table_scorer: two instances (settle 4 and settle 1) driven by
// candidate models, checked every cycle against a timeline-level reference model.
module tb_truth_table_scorer;

    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start      [NI];
    logic [63:0] target     [NI];
    logic [3:0]  dut_in     [NI];
    logic [3:0]  dut_out    [NI];
    logic        busy       [NI];
    logic        done       [NI];
    logic [6:0]  score      [NI];
    logic [15:0] mask       [NI];

    // Candidate behaviour: 0 loop-back, 1 tied to zero, 2 lags dut_in by two cycles, 3 lookup table.
    int          cand_mode  [NI];
    logic [3:0]  cand_tbl   [NI][16];
    logic [3:0]  lag1       [NI];
    logic [3:0]  lag2       [NI];

    int          m_cyc      [NI] = '{0, 0};
    logic [6:0]  m_score    [NI];
    logic [15:0] m_mask     [NI];
    logic [22:0] pend_res   [NI];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    bit          chk_en   = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        truth_table_scorer #(
            .N_IN          (4),
            .N_OUT         (4),
            .SETTLE_CYCLES ((g == 0) ? 4 : 1)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .start         (start[g]),
            .target        (target[g]),
            .dut_in        (dut_in[g]),
            .dut_out       (dut_out[g]),
            .busy          (busy[g]),
            .done          (done[g]),
            .score         (score[g]),
            .mismatch_mask (mask[g])
        );
    end

    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            lag1[g] <= dut_in[g];
            lag2[g] <= lag1[g];
        end
    end

    always_comb begin
        for (int g = 0; g < NI; g++) begin
            dut_out[g] = dut_in[g];
            case (cand_mode[g])
                1:       dut_out[g] = 4'h0;
                2:       dut_out[g] = lag2[g];
                3:       dut_out[g] = cand_tbl[g][dut_in[g]];
                default: ;
            endcase
        end
    end

    function automatic int settle(input int g);
        return (g == 0) ? 4 : 1;
    endfunction

    function automatic int done_cyc(input int g);
        return 16 * (settle(g) + 1) + 1;
    endfunction

    // Candidate response seen at the sampling cycle of vector v.
    function automatic logic [3:0] cand_resp(input int g, input int mode, input int v);
        int s;
        int c;
        s = settle(g);
        case (mode)
            0: return 4'(v);
            1: return 4'h0;
            2: begin
                c = (v + 1) * (s + 1) - 2;
                return (c <= 0) ? 4'h0 : 4'((c - 1) / (s + 1));
            end
            default: return cand_tbl[g][v];
        endcase
    endfunction

    function automatic logic [22:0] model_eval(input logic [63:0] t, input int mode, input int g);
        logic [6:0]  sc;
        logic [15:0] mk;
        logic [3:0]  diff;
        sc = '0;
        mk = '0;
        for (int v = 0; v < 16; v++) begin
            diff  = cand_resp(g, mode, v) ^ t[v*4 +: 4];
            sc    = sc + 7'(4 - $countones(diff));
            mk[v] = (diff != 4'h0);
        end
        return {sc, mk};
    endfunction

    function automatic logic [63:0] ident_tgt();
        logic [63:0] t;
        for (int v = 0; v < 16; v++) t[v*4 +: 4] = 4'(v);
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 50) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: position in the run timeline and last completed result.
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst_n) begin
                m_cyc[g]   <= 0;
                m_score[g] <= '0;
                m_mask[g]  <= '0;
            end else if (m_cyc[g] == 0) begin
                if (start[g]) begin
                    m_cyc[g]    <= 1;
                    pend_res[g] <= model_eval(target[g], cand_mode[g], g);
                end
            end else if (m_cyc[g] == done_cyc(g)) begin
                m_cyc[g] <= 0;
            end else begin
                m_cyc[g] <= m_cyc[g] + 1;
                if (m_cyc[g] == done_cyc(g) - 1) begin
                    m_score[g] <= pend_res[g][22:16];
                    m_mask[g]  <= pend_res[g][15:0];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < NI; g++) begin
                check($sformatf("busy[%0d]", g),  64'(busy[g]),  64'(m_cyc[g] != 0));
                check($sformatf("done[%0d]", g),  64'(done[g]),  64'(m_cyc[g] == done_cyc(g)));
                check($sformatf("score[%0d]", g), 64'(score[g]), 64'(m_score[g]));
                check($sformatf("mask[%0d]", g),  64'(mask[g]),  64'(m_mask[g]));
                if (m_cyc[g] != done_cyc(g)) begin
                    check($sformatf("dut_in[%0d]", g), 64'(dut_in[g]),
                          (m_cyc[g] == 0) ? 64'd0 : 64'((m_cyc[g] - 1) / (settle(g) + 1)));
                end
            end
        end
    end

    task automatic run_eval(input int g, input logic [63:0] t, input int mode,
                            input int restart_at, output int done_at);
        int cyc;
        @(negedge clk);
        target[g]    = t;
        cand_mode[g] = mode;
        start[g]     = 1'b1;
        @(negedge clk);
        start[g]  = 1'b0;
        target[g] = {$urandom, $urandom};
        cyc       = 1;
        done_at   = -1;
        while (cyc <= 300) begin
            if (done[g]) begin
                done_at = cyc;
                break;
            end
            start[g] = (cyc == restart_at);
            @(negedge clk);
            cyc++;
        end
        start[g] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d;
        int          cyc;
        int          first;
        int          second;
        int          extra;
        int          g;
        int          mode;
        logic [63:0] ident;

        ident = ident_tgt();
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start[i]     = 1'b0;
            target[i]    = '0;
            cand_mode[i] = 0;
            for (int v = 0; v < 16; v++) cand_tbl[i][v] = 4'($urandom_range(0, 15));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy",   64'(busy[0]),   64'd0);
        check("reset_done",   64'(done[0]),   64'd0);
        check("reset_dut_in", 64'(dut_in[0]), 64'd0);
        check("reset_score",  64'(score[0]),  64'd0);
        check("reset_mask",   64'(mask[0]),   64'd0);
        rst_n = 1'b1;

        run_eval(0, ident, 0, -1, d);
        check("ident_done_at", 64'(d), 64'd81);
        check("ident_score", 64'(score[0]), 64'd64);
        check("ident_mask", 64'(mask[0]), 64'h0);
        check("ident_model_score", 64'(m_score[0]), 64'd64);

        run_eval(0, 64'h0, 1, -1, d);
        check("zero_zero_score", 64'(score[0]), 64'd64);
        check("zero_zero_mask", 64'(mask[0]), 64'h0);

        run_eval(0, {64{1'b1}}, 1, -1, d);
        check("zero_ones_score", 64'(score[0]), 64'd0);
        check("zero_ones_mask", 64'(mask[0]), 64'hFFFF);
        check("zero_ones_model_mask", 64'(m_mask[0]), 64'hFFFF);

        run_eval(0, ident ^ (64'd1 << 22), 0, -1, d);
        check("flip_score", 64'(score[0]), 64'd63);
        check("flip_mask", 64'(mask[0]), 64'h0020);

        run_eval(0, ident, 0, 30, d);
        check("restart_done_at", 64'(d), 64'd81);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (done[0]) extra++;
        end
        check("restart_extra_done", 64'(extra), 64'd0);
        check("restart_idle_busy", 64'(busy[0]), 64'd0);

        @(negedge clk);
        target[0]    = ident;
        cand_mode[0] = 0;
        start[0]     = 1'b1;
        @(negedge clk);
        cyc    = 1;
        first  = -1;
        second = -1;
        while (cyc <= 400) begin
            if (done[0]) begin
                if (first < 0) first = cyc;
                else begin
                    second = cyc;
                    break;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start[0] = 1'b0;
        check("held_first_done", 64'(first), 64'd81);
        check("held_second_done", 64'(second), 64'd163);
        check("held_score", 64'(score[0]), 64'd64);

        @(negedge clk);
        @(negedge clk);
        target[0]    = ident;
        cand_mode[0] = 1;
        start[0]     = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cyc      = 1;
        while (cyc < 37) begin
            @(negedge clk);
            cyc++;
        end
        check("pre_reset_vec7", 64'(dut_in[0]), 64'd7);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 64'(busy[0]), 64'd0);
        check("abort_dut_in", 64'(dut_in[0]), 64'd0);
        check("abort_score", 64'(score[0]), 64'd0);
        check("abort_mask", 64'(mask[0]), 64'd0);
        extra = 0;
        repeat (120) begin
            @(negedge clk);
            if (done[0]) extra++;
        end
        check("abort_no_done", 64'(extra), 64'd0);
        run_eval(0, ident, 0, -1, d);
        check("post_reset_done_at", 64'(d), 64'd81);
        check("post_reset_score", 64'(score[0]), 64'd64);

        run_eval(0, ident, 2, -1, d);
        check("lag_s4_score", 64'(score[0]), 64'd64);
        check("lag_s4_mask", 64'(mask[0]), 64'h0);

        run_eval(1, ident, 2, -1, d);
        check("lag_s1_done_at", 64'(d), 64'd33);
        check("lag_s1_score", 64'(score[1]), 64'd38);
        check("lag_s1_mask", 64'(mask[1]), 64'hFFFE);
        check("lag_s1_model_score", 64'(m_score[1]), 64'd38);

        for (int it = 0; it < 10; it++) begin
            g    = $urandom_range(0, 1);
            mode = $urandom_range(0, 3);
            for (int v = 0; v < 16; v++) cand_tbl[g][v] = 4'($urandom_range(0, 15));
            run_eval(g, {$urandom, $urandom}, mode, -1, d);
            check($sformatf("rand%0d_done_at", it), 64'(d), 64'(done_cyc(g)));
            check($sformatf("rand%0d_score", it), 64'(score[g]), 64'(m_score[g]));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/truth_table_scorer.md
# truth_table_scorer

Upstream driver and fitness evaluator for an evolved combinational candidate with 4 inputs and 4 outputs. It walks all 16 input vectors into the candidate and waits a programmable settle time after each one. It then compares the candidate's outputs against a target truth table and reports a match count (fitness) and a per-vector mismatch mask to the evolution controller.

## Interface
Parameters:
- N_IN, 4: candidate input width; vectors walked = 2**N_IN.
- N_OUT, 4: candidate output width.
- SETTLE_CYCLES, 4: clock cycles `dut_in` is held before sampling. Legal range is 1 or more.
  - SETTLE_CYCLES × clock period must exceed the candidate's worst-case gate-path delay.

Ports:
- clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- start, in, 1: request an evaluation; sampled only in IDLE.
- target, in, N_OUT*2**N_IN (64): expected outputs. Bit `v*N_OUT+o` is output o for input vector v. Captured on start.
- dut_in, out, N_IN: vector applied to the candidate.
- dut_out, in, N_OUT: candidate response.
- busy, out, 1: evaluation in progress.
- done, out, 1: one-cycle pulse when the result is updated.
- score, out, 7: total matching output bits, range 0..64.
- mismatch_mask, out, 2**N_IN: bit v set if any output mismatched for vector v.

## Operation
States:
- IDLE
  - busy=0; dut_in=0.
  - If start=1: capture target, clear the accumulator and working mask, set vec=0, load the settle counter, go to WAIT.
- WAIT
  - dut_in=vec; counter decrements.
  - After SETTLE_CYCLES cycles, go to SAMPLE.
- SAMPLE
  - Compare dut_out against target slice vec.
  - Add the popcount of matching bits (XNOR) to the accumulator.
  - If the popcount is less than N_OUT, set working-mask bit vec.
  - If vec is the last vector (2**N_IN−1), go to DONE. Otherwise increment vec, reload the counter, and go to WAIT.
  - The comparison uses the final accumulator value, including the last vector's contribution.
- DONE
  - Copy the accumulator to score and the working mask to mismatch_mask.
  - done=1 for this cycle only; go to IDLE.

Rules:
- start is ignored while busy; there is no queueing. If start is held high, a new run begins in the IDLE cycle after DONE.
- score and mismatch_mask hold the last completed result. They change only in DONE.
- target changes after capture do not affect the current run.
- The accumulator is 7 bits and cannot overflow (maximum 64).
- Reset at any point:
  - State returns to IDLE.
  - busy, done, dut_in, score and mismatch_mask all go to 0.
  - No done pulse is issued for the aborted run.

## Timing
- Reset values: busy=0, done=0, dut_in=0, score=0, mismatch_mask=0.
- All outputs are registered.
- Call the edge that captures start cycle 0.
  - busy=1 from cycle 1 through the DONE cycle.
  - Vector v is driven in cycles v*(S+1)+1 through v*(S+1)+S.
  - Vector v is compared in SAMPLE cycle (v+1)*(S+1).
  - DONE (done=1, results valid) is cycle 16*(S+1)+1; with S=4 this is cycle 81.
- dut_in changes only on the edge entering WAIT for a new vector, so it is glitch-free per cycle.
- dut_out is treated as combinational from dut_in and is not synchronised.

## Structure
- Package `scorer_pkg` holds:
  - State enum {IDLE, WAIT, SAMPLE, DONE}.
  - localparams N_VEC = 2**N_IN and SCORE_W = $clog2(N_OUT*N_VEC+1).
  - A function extracting target slice v.
- Sub-module `match_popcount`: N_OUT-bit XNOR of dut_out against the expected slice, producing a popcount of width $clog2(N_OUT+1). Purely combinational.

## Test plan
- Loop-back with dut_out=dut_in and target = identity table, S=4:
  - score=64, mismatch_mask=16'h0000.
  - done is a single pulse at cycle 81; busy high in cycles 1–81.
- dut_out tied to 0:
  - Target all-zero: score=64, mask=0.
  - Target all-one: score=0, mask=16'hFFFF.
- Identity loop-back with target bit (v=5, o=2) flipped: score=63, mask=16'h0020.
- start pulsed again at cycle 30 of a run: ignored; exactly one done, at cycle 81.
  - With start held high throughout: back-to-back runs, second done at cycle 163.
- rst_n low for one cycle while vec=7:
  - Next cycle busy=0, dut_in=0, score=0, mask=0; no done.
  - A fresh start then completes normally.
- Candidate model whose output lags dut_in by 2 cycles, identity target:
  - S=4: score=64.
  - S=1: every vector whose output differs from the previous vector's mismatches, so score < 64 and the mask is nonzero.
